// File: rtl/maze_ram_arbiter_if.sv
// Bus bundle between the maze RAM arbiter, its requesters and the maze tile RAM.
// slave  = the arbiter's view, master = requesters plus the RAM.
interface maze_ram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int N_REQ  = 3
);
  // video read port
  logic                      vid_req;
  logic [ADDR_W-1:0]         vid_addr;
  logic                      vid_valid;
  logic [1:0]                vid_data;
  // game-logic read ports
  logic [N_REQ-1:0]          rd_req;
  logic [N_REQ*ADDR_W-1:0]   rd_addr;
  logic [N_REQ-1:0]          rd_gnt;
  logic [N_REQ-1:0]          rd_valid;
  logic [1:0]                rd_data;
  logic                      rd_err;
  // game-logic write port
  logic                      wr_req;
  logic [ADDR_W-1:0]         wr_addr;
  logic [1:0]                wr_data;
  logic                      wr_gnt;
  // fill engine control / status
  logic                      fill_start;
  logic [1:0]                fill_value;
  logic                      fill_busy;
  logic                      starve;
  // maze RAM pins
  logic [ADDR_W-1:0]         ram_read_address;
  logic [ADDR_W-1:0]         ram_write_address;
  logic [1:0]                ram_data_In;
  logic                      ram_we;
  logic [1:0]                ram_data_Out;

  modport slave (
    input  vid_req, vid_addr, rd_req, rd_addr, wr_req, wr_addr, wr_data,
           fill_start, fill_value, ram_data_Out,
    output vid_valid, vid_data, rd_gnt, rd_valid, rd_data, rd_err, wr_gnt,
           fill_busy, starve, ram_read_address, ram_write_address, ram_data_In, ram_we
  );

  modport master (
    output vid_req, vid_addr, rd_req, rd_addr, wr_req, wr_addr, wr_data,
           fill_start, fill_value, ram_data_Out,
    input  vid_valid, vid_data, rd_gnt, rd_valid, rd_data, rd_err, wr_gnt,
           fill_busy, starve, ram_read_address, ram_write_address, ram_data_In, ram_we
  );
endinterface

// File: rtl/maze_ram_arbiter.sv
// Maze tile RAM arbiter: video has absolute read priority, game readers share
// the rest round-robin, the dot writer and the fill engine share the write port.
// Same-cycle write/read collisions return the new data.
module maze_ram_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int MAX_ADDR = 32843,
  parameter int N_REQ    = 3,
  parameter int STARVE   = 1023
) (
  input  logic              Clk,
  input  logic              Reset_n,
  maze_ram_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE + 1);
  localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
  localparam logic [CNT_W-1:0]  STARVE_C = CNT_W'(STARVE);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} fill_state_t;

  fill_state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]            fill_cnt_reg, fill_cnt_next;
  logic [1:0]                   fill_val_reg, fill_val_next;
  logic [PTR_W-1:0]             ptr_reg, ptr_next;
  logic [N_REQ-1:0][CNT_W-1:0]  wait_reg, wait_next;
  logic [N_REQ-1:0]             starve_hit;
  logic                         starve_reg;

  logic [ADDR_W-1:0]            req_addr [N_REQ];
  logic [PTR_W-1:0]             rr_idx   [N_REQ];
  logic                         gnt_any;
  logic [PTR_W-1:0]             gnt_idx;
  logic [N_REQ-1:0]             gnt_vec;
  logic                         issue_any, issue_ok;
  logic [ADDR_W-1:0]            issue_addr;
  logic                         fill_active, wr_ok, we_c, fwd_hit;
  logic [ADDR_W-1:0]            wa_c;
  logic [1:0]                   wd_c;

  logic                         vid_valid_reg;
  logic [N_REQ-1:0]             rd_valid_reg;
  logic                         rd_err_reg, drop_reg, fwd_reg;
  logic [1:0]                   fwd_data_reg, ret_data;

  // Unpack requester addresses, build the rotated search order and the wait counters.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_addr[gi]   = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign rr_idx[gi]     = PTR_W'((int'(ptr_reg) + gi) % N_REQ);
      assign wait_next[gi]  = gnt_vec[gi] ? '0 :
                              (bus.rd_req[gi] && wait_reg[gi] != STARVE_C) ? wait_reg[gi] + 1'b1 :
                              wait_reg[gi];
      assign starve_hit[gi] = (wait_next[gi] == STARVE_C);
    end
  endgenerate

  // Round-robin pick: nearest requester at or above the pointer; video blocks all game reads.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.rd_req[rr_idx[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx[k];
      end
    end
    if (bus.vid_req) gnt_any = 1'b0;
    gnt_vec  = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    ptr_next = gnt_any ? PTR_W'((int'(gnt_idx) + 1) % N_REQ) : ptr_reg;
  end

  // Read issue and write-port selection; out-of-range reads never reach the RAM.
  always_comb begin
    issue_any   = bus.vid_req | gnt_any;
    issue_addr  = bus.vid_req ? bus.vid_addr : req_addr[gnt_idx];
    issue_ok    = issue_any && (issue_addr <= MAX_A);
    fill_active = (state_reg == FILL);
    wr_ok       = !fill_active && bus.wr_req && (bus.wr_addr <= MAX_A);
    we_c        = fill_active | wr_ok;
    wa_c        = fill_active ? fill_cnt_reg : (wr_ok ? bus.wr_addr : '0);
    wd_c        = fill_active ? fill_val_reg : (wr_ok ? bus.wr_data : 2'b00);
    fwd_hit     = we_c && issue_ok && (wa_c == issue_addr);
  end

  // Fill engine next state: walk every address once, then return to idle.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    fill_val_next = fill_val_reg;
    case (state_reg)
      IDLE: begin
        if (bus.fill_start) begin
          state_next    = FILL;
          fill_cnt_next = '0;
          fill_val_next = bus.fill_value;
        end
      end
      FILL: begin
        if (fill_cnt_reg == MAX_A) state_next = IDLE;
        else                       fill_cnt_next = fill_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, arbitration and return-path registers; reset drops any read in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      fill_cnt_reg  <= '0;
      fill_val_reg  <= 2'b00;
      ptr_reg       <= '0;
      wait_reg      <= '0;
      starve_reg    <= 1'b0;
      vid_valid_reg <= 1'b0;
      rd_valid_reg  <= '0;
      rd_err_reg    <= 1'b0;
      drop_reg      <= 1'b0;
      fwd_reg       <= 1'b0;
      fwd_data_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      fill_val_reg  <= fill_val_next;
      ptr_reg       <= ptr_next;
      wait_reg      <= wait_next;
      starve_reg    <= starve_reg | (|starve_hit);
      vid_valid_reg <= bus.vid_req;
      rd_valid_reg  <= gnt_vec;
      rd_err_reg    <= gnt_any && !issue_ok;
      drop_reg      <= issue_any && !issue_ok;
      fwd_reg       <= fwd_hit;
      fwd_data_reg  <= wd_c;
    end
  end

  assign ret_data              = drop_reg ? 2'b00 : (fwd_reg ? fwd_data_reg : bus.ram_data_Out);
  assign bus.vid_valid         = vid_valid_reg;
  assign bus.vid_data          = ret_data;
  assign bus.rd_gnt            = gnt_vec;
  assign bus.rd_valid          = rd_valid_reg;
  assign bus.rd_data           = ret_data;
  assign bus.rd_err            = rd_err_reg;
  assign bus.wr_gnt            = wr_ok;
  assign bus.fill_busy         = fill_active;
  assign bus.starve            = starve_reg;
  assign bus.ram_read_address  = issue_ok ? issue_addr : '0;
  assign bus.ram_write_address = wa_c;
  assign bus.ram_data_In       = wd_c;
  assign bus.ram_we            = we_c;
endmodule

// File: tb/tb_maze_ram_arbiter.sv
// Randomized and directed bench for maze_ram_arbiter against a behavioural
// model: reads see memory contents after any same-cycle write.
module tb_maze_ram_arbiter;
  localparam int ADDR_W   = 19;
  localparam int MAX_ADDR = 32843;
  localparam int N_REQ    = 3;
  localparam int STARVE   = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_ram_arbiter_if #(.ADDR_W(ADDR_W), .N_REQ(N_REQ)) bus ();

  maze_ram_arbiter #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR), .N_REQ(N_REQ), .STARVE(STARVE)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Maze RAM: registered read, old data on read-during-write.
  bit [1:0] ram_mem [0:MAX_ADDR];
  bit [1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we && int'(bus.ram_write_address) <= MAX_ADDR)
      ram_mem[bus.ram_write_address[15:0]] <= bus.ram_data_In;
    ram_q <= (int'(bus.ram_read_address) <= MAX_ADDR) ? ram_mem[bus.ram_read_address[15:0]] : 2'b00;
  end
  assign bus.ram_data_Out = ram_q;

  // Reference model state
  bit [1:0] ref_mem [0:MAX_ADDR];
  int       m_ptr;
  bit       m_fill;
  int       m_fill_cnt;
  bit [1:0] m_fill_val;
  int       m_wait [N_REQ];
  bit       m_starve;
  int       last_gnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rd_addr_of(input int i);
    return int'(bus.rd_addr[i*ADDR_W +: ADDR_W]);
  endfunction

  task automatic set_rd(input int i, input int a);
    bus.rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  function automatic int rand_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return MAX_ADDR + 1 + int'($urandom_range(0, 3));
    if (r == 1) return MAX_ADDR - int'($urandom_range(0, 3));
    return int'($urandom_range(0, 31));
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_fill = 1'b0; m_fill_cnt = 0; m_fill_val = 2'b00;
    m_starve = 1'b0; last_gnt = -1;
    for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
  endtask

  task automatic idle();
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.rd_req = '0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = 2'b00;
    bus.fill_start = 1'b0; bus.fill_value = 2'b00;
  endtask

  task automatic rand_inputs(input bit in_fill);
    bus.vid_req  = ($urandom_range(0, 2) == 0);
    bus.vid_addr = ADDR_W'(rand_addr());
    for (int i = 0; i < N_REQ; i++) begin
      if (!bus.rd_req[i] || last_gnt == i) begin
        bus.rd_req[i] = 1'($urandom_range(0, 1));
        set_rd(i, rand_addr());
      end
    end
    bus.wr_req     = 1'($urandom_range(0, 1));
    bus.wr_addr    = ADDR_W'(rand_addr());
    bus.wr_data    = 2'($urandom_range(0, 3));
    bus.fill_start = in_fill ? ($urandom_range(0, 63) == 0) : 1'b0;
    bus.fill_value = 2'($urandom_range(0, 3));
  endtask

  // One clock: check issue-cycle outputs, advance the model, check returned data.
  task automatic step();
    int g, ra, e_ra, wa, idx;
    bit do_w, e_wg, e_vv, e_err;
    bit [1:0] wd, e_rd;
    bit [N_REQ-1:0] e_gnt;
    #1;
    if (m_fill) begin
      do_w = 1'b1; wa = m_fill_cnt; wd = m_fill_val; e_wg = 1'b0;
    end else begin
      e_wg = bus.wr_req && (int'(bus.wr_addr) <= MAX_ADDR);
      do_w = e_wg; wa = int'(bus.wr_addr); wd = bus.wr_data;
    end
    g = -1;
    if (!bus.vid_req) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (g < 0 && bus.rd_req[idx]) g = idx;
      end
    end
    e_gnt = (g >= 0) ? N_REQ'(1 << g) : '0;
    ra    = bus.vid_req ? int'(bus.vid_addr) : ((g >= 0) ? rd_addr_of(g) : -1);
    e_ra  = (ra >= 0 && ra <= MAX_ADDR) ? ra : 0;
    chk("rd_gnt", 32'(bus.rd_gnt), 32'(e_gnt));
    chk("wr_gnt", 32'(bus.wr_gnt), 32'(e_wg));
    chk("ram_we", 32'(bus.ram_we), 32'(do_w));
    chk("ram_read_address", 32'(bus.ram_read_address), e_ra);
    if (do_w) begin
      chk("ram_write_address", 32'(bus.ram_write_address), wa);
      chk("ram_data_In", 32'(bus.ram_data_In), 32'(wd));
      ref_mem[16'(wa)] = wd;
    end
    e_vv  = bus.vid_req;
    e_err = (g >= 0) && (ra > MAX_ADDR);
    e_rd  = (ra >= 0 && ra <= MAX_ADDR) ? ref_mem[16'(ra)] : 2'b00;
    if (g >= 0) m_ptr = (g + 1) % N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (g == i) m_wait[i] = 0;
      else if (bus.rd_req[i] && m_wait[i] < STARVE) m_wait[i]++;
      if (m_wait[i] >= STARVE) m_starve = 1'b1;
    end
    if (m_fill) begin
      if (m_fill_cnt == MAX_ADDR) m_fill = 1'b0;
      else m_fill_cnt++;
    end else if (bus.fill_start) begin
      m_fill = 1'b1; m_fill_cnt = 0; m_fill_val = bus.fill_value;
    end
    last_gnt = g;
    @(posedge clk);
    #1;
    chk("vid_valid", 32'(bus.vid_valid), 32'(e_vv));
    chk("rd_valid", 32'(bus.rd_valid), 32'(e_gnt));
    chk("rd_err", 32'(bus.rd_err), 32'(e_err));
    if (e_vv) chk("vid_data", 32'(bus.vid_data), 32'(e_rd));
    if (e_gnt != 0) chk("rd_data", 32'(bus.rd_data), 32'(e_rd));
    chk("starve", 32'(bus.starve), 32'(m_starve));
    chk("fill_busy", 32'(bus.fill_busy), 32'(m_fill));
  endtask

  initial begin
    int busy_cnt, got;
    bit done;
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vid_valid", 32'(bus.vid_valid), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_err", 32'(bus.rd_err), 0);
    chk("rst_fill_busy", 32'(bus.fill_busy), 0);
    chk("rst_starve", 32'(bus.starve), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Round robin with all three requesting
    bus.rd_req = 3'b111;
    set_rd(0, 10); set_rd(1, 11); set_rd(2, 12);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_valid", 32'(bus.rd_valid), 32'(1 << (k % 3)));
    end

    // Video beats game
    idle();
    bus.vid_req = 1'b1; bus.vid_addr = ADDR_W'(3);
    bus.rd_req = 3'b001; set_rd(0, 20);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("vb_vid_valid", 32'(bus.vid_valid), 1);
      chk("vb_rd_valid", 32'(bus.rd_valid), 0);
    end
    bus.vid_req = 1'b0;
    step();
    chk("vb_rd_valid_after", 32'(bus.rd_valid), 1);

    // Forwarding
    idle();
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'(100); bus.wr_data = 2'd1;
    step();
    bus.wr_data = 2'd3;
    bus.rd_req = 3'b001; set_rd(0, 100);
    step();
    chk("fwd_valid", 32'(bus.rd_valid), 1);
    chk("fwd_data", 32'(bus.rd_data), 3);

    // Out-of-range read and write
    idle();
    bus.rd_req = 3'b001; set_rd(0, MAX_ADDR + 1);
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'(MAX_ADDR + 1); bus.wr_data = 2'd1;
    #1;
    chk("range_wr_gnt", 32'(bus.wr_gnt), 0);
    chk("range_ram_we", 32'(bus.ram_we), 0);
    chk("range_ram_rd_addr", 32'(bus.ram_read_address), 0);
    step();
    chk("range_err", 32'(bus.rd_err), 1);
    chk("range_data", 32'(bus.rd_data), 0);

    // Random traffic
    idle();
    for (int n = 0; n < 1500; n++) begin
      rand_inputs(1'b0);
      step();
    end

    // Fill with value 2 while random traffic continues
    idle();
    bus.fill_start = 1'b1; bus.fill_value = 2'd2;
    step();
    busy_cnt = bus.fill_busy ? 1 : 0;
    done = 1'b0;
    for (int c = 0; c < MAX_ADDR + 20 && !done; c++) begin
      rand_inputs(1'b1);
      step();
      if (bus.fill_busy) busy_cnt++;
      else done = 1'b1;
    end
    chk("fill_cycles", busy_cnt, MAX_ADDR + 1);

    idle();
    bus.rd_req = 3'b011; set_rd(0, 0); set_rd(1, MAX_ADDR);
    got = 0;
    for (int c = 0; c < 4 && got != 3; c++) begin
      step();
      if (bus.rd_valid[0]) begin chk("fill_rd_lo", 32'(bus.rd_data), 2); got |= 1; end
      if (bus.rd_valid[1]) begin chk("fill_rd_hi", 32'(bus.rd_data), 2); got |= 2; end
      if (last_gnt >= 0) bus.rd_req[last_gnt] = 1'b0;
    end
    chk("fill_rd_done", got, 3);

    // Starvation under continuous video traffic
    idle();
    chk("starve_pre", 32'(bus.starve), 0);
    bus.vid_req = 1'b1; bus.vid_addr = ADDR_W'(9);
    bus.rd_req = 3'b100; set_rd(2, 7);
    for (int c = 0; c < STARVE + 2; c++) step();
    chk("starve_set", 32'(bus.starve), 1);

    // Reset in the middle of a read and a fill
    idle();
    bus.rd_req = 3'b001; set_rd(0, 5);
    bus.fill_start = 1'b1; bus.fill_value = 2'd1;
    step();
    chk("mid_rd_valid", 32'(bus.rd_valid), 1);
    chk("mid_fill_busy", 32'(bus.fill_busy), 1);
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_mid_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_mid_vid_valid", 32'(bus.vid_valid), 0);
    chk("rst_mid_fill_busy", 32'(bus.fill_busy), 0);
    chk("rst_mid_starve", 32'(bus.starve), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_rd_valid", 32'(bus.rd_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
